wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline writeback result (already selected between ALU and data memory) and an out-of-band multi-cycle extension unit (e.g. M-extension divider). Pipeline results have priority; extension results are buffered in a small FIFO and drained on idle pipeline cycles. A starvation guard forces a one-cycle pipeline stall so buffered results always retire. It also exports a pending-destination mask for the hazard/scoreboard logic.

---
 rtl/wb_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the pipeline
// writeback and a buffered extension unit. The pipeline has priority. A
// starvation guard stalls the pipeline for one cycle so that buffered
// extension results always retire.
module wb_port_arbiter #(
    parameter int XLEN       = 64,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_valid,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    output logic            pipe_stall,
    input  logic            ext_valid,
    output logic            ext_ready,
    input  logic [4:0]      ext_rd,
    input  logic [XLEN-1:0] ext_data,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     ext_pending_mask
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic {NORMAL, FORCE} state_t;

    state_t                state, state_nxt;
    logic [WAIT_W-1:0]     wait_cnt, wait_nxt;

    logic [4:0]            fifo_rd   [FIFO_DEPTH];
    logic [XLEN-1:0]       fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_vld;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;

    logic                  fifo_empty;
    logic                  push, pop, bypass;
    logic                  grant_valid;
    logic [4:0]            grant_rd;
    logic [XLEN-1:0]       grant_data;

    assign fifo_empty = (count == '0);
    assign ext_ready  = (count != FULL_CNT);
    assign pipe_stall = (state == FORCE);
    assign push       = ext_valid && ext_ready && !bypass;

    // Grant selection, starvation counting and next state.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        pop         = 1'b0;
        bypass      = 1'b0;
        grant_valid = 1'b0;
        grant_rd    = pipe_rd;
        grant_data  = pipe_data;
        case (state)
            NORMAL: begin
                if (pipe_valid) begin
                    grant_valid = 1'b1;
                    if (!fifo_empty) begin
                        // Head is blocked by the pipeline this cycle.
                        if (wait_cnt == WAIT_MAX) state_nxt = FORCE;
                        else                      wait_nxt  = wait_cnt + 1'b1;
                    end
                end else if (!fifo_empty) begin
                    pop         = 1'b1;
                    grant_valid = 1'b1;
                    grant_rd    = fifo_rd[rd_ptr];
                    grant_data  = fifo_data[rd_ptr];
                    wait_nxt    = '0;
                end else if (ext_valid) begin
                    // Empty buffer and idle pipeline: write the result straight through.
                    bypass      = 1'b1;
                    grant_valid = 1'b1;
                    grant_rd    = ext_rd;
                    grant_data  = ext_data;
                end
            end
            FORCE: begin
                // Pipeline request is held off by pipe_stall; drain one entry.
                pop         = !fifo_empty;
                grant_valid = !fifo_empty;
                grant_rd    = fifo_rd[rd_ptr];
                grant_data  = fifo_data[rd_ptr];
                wait_nxt    = '0;
                state_nxt   = NORMAL;
            end
            default: state_nxt = NORMAL;
        endcase
    end

    // State, starvation counter and FIFO bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= NORMAL;
            wait_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fifo_vld <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (pop) begin
                fifo_vld[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + 1'b1;
            end
            if (push) begin
                fifo_vld[wr_ptr] <= 1'b1;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO payload storage.
    // NOTE: the payload array is not reset; fifo_vld and count decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= ext_rd;
            fifo_data[wr_ptr] <= ext_data;
        end
    end

    // Registered register-file write port; x0 writes are consumed but suppressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= grant_valid && (grant_rd != 5'd0);
            if (grant_valid) begin
                rf_rd    <= grant_rd;
                rf_wdata <= grant_data;
            end
        end
    end

    // Destinations of buffered entries, for the hazard scoreboard.
    always_comb begin
        ext_pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_vld[i]) ext_pending_mask[fifo_rd[i]] = 1'b1;
        end
        ext_pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with default parameters
// (XLEN=64, FIFO_DEPTH=2, MAX_WAIT=4).
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [63:0] pipe_data;
    logic        pipe_stall;
    logic        ext_valid;
    logic        ext_ready;
    logic [4:0]  ext_rd;
    logic [63:0] ext_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [63:0] rf_wdata;
    logic [31:0] ext_pending_mask;

    int num_checks = 0;
    int num_errors = 0;

    wb_port_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .pipe_valid       (pipe_valid),
        .pipe_rd          (pipe_rd),
        .pipe_data        (pipe_data),
        .pipe_stall       (pipe_stall),
        .ext_valid        (ext_valid),
        .ext_ready        (ext_ready),
        .ext_rd           (ext_rd),
        .ext_data         (ext_data),
        .rf_we            (rf_we),
        .rf_rd            (rf_rd),
        .rf_wdata         (rf_wdata),
        .ext_pending_mask (ext_pending_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and sample just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pipe(input logic v, input logic [4:0] rd, input logic [63:0] d);
        pipe_valid = v;
        pipe_rd    = rd;
        pipe_data  = d;
    endtask

    task automatic set_ext(input logic v, input logic [4:0] rd, input logic [63:0] d);
        ext_valid = v;
        ext_rd    = rd;
        ext_data  = d;
    endtask

    initial begin
        rst = 1'b1;
        set_pipe(1'b0, 5'd0, 64'h0);
        set_ext(1'b0, 5'd0, 64'h0);
        #1;
        // Reset values
        check("rst_we",    rf_we, 0);
        check("rst_rd",    rf_rd, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_stall", pipe_stall, 0);
        check("rst_ready", ext_ready, 1);
        check("rst_mask",  ext_pending_mask, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_we", rf_we, 0);

        // Bypass: idle pipeline, empty FIFO
        set_ext(1'b1, 5'd5, 64'hDEAD);
        check("byp_ready", ext_ready, 1);
        tick();
        check("byp_we",    rf_we, 1);
        check("byp_rd",    rf_rd, 5);
        check("byp_wdata", rf_wdata, 64'hDEAD);
        check("byp_mask",  ext_pending_mask, 0);
        set_ext(1'b0, 5'd0, 64'h0);
        tick();
        check("byp_done_we", rf_we, 0);

        // Priority and buffering under continuous pipe_valid
        set_pipe(1'b1, 5'd1, 64'h101);
        set_ext(1'b1, 5'd7, 64'h707);
        tick();
        check("pri_we1",    rf_we, 1);
        check("pri_rd1",    rf_rd, 1);
        check("pri_mask1",  ext_pending_mask, 32'h80);
        check("pri_ready1", ext_ready, 1);
        set_pipe(1'b1, 5'd2, 64'h102);
        set_ext(1'b1, 5'd9, 64'h909);
        tick();
        check("pri_rd2",    rf_rd, 2);
        check("pri_mask2",  ext_pending_mask, 32'h280);
        check("pri_ready2", ext_ready, 0);
        set_ext(1'b0, 5'd0, 64'h0);
        for (int k = 3; k <= 5; k++) begin
            set_pipe(1'b1, 5'(k), 64'h100 + 64'(k));
            tick();
            check("pri_we_k",    rf_we, 1);
            check("pri_rd_k",    rf_rd, 5'(k));
            check("pri_stall_k", pipe_stall, (k == 5) ? 1 : 0);
        end
        // FORCE cycle: pipeline holds rd=6
        set_pipe(1'b1, 5'd6, 64'h106);
        tick();
        check("frc_rd",    rf_rd, 7);
        check("frc_wdata", rf_wdata, 64'h707);
        check("frc_stall", pipe_stall, 0);
        check("frc_mask",  ext_pending_mask, 32'h200);
        check("frc_ready", ext_ready, 1);
        tick();
        check("held_rd",    rf_rd, 6);
        check("held_wdata", rf_wdata, 64'h106);
        set_pipe(1'b0, 5'd0, 64'h0);
        tick();
        check("drain_rd",    rf_rd, 9);
        check("drain_wdata", rf_wdata, 64'h909);
        check("drain_mask",  ext_pending_mask, 0);
        tick();
        check("drain_idle_we", rf_we, 0);

        // Starvation guard: one buffered entry rd=3
        set_pipe(1'b1, 5'd10, 64'h110);
        set_ext(1'b1, 5'd3, 64'h333);
        tick();
        check("stv_rd0",   rf_rd, 10);
        check("stv_mask0", ext_pending_mask, 32'h8);
        set_ext(1'b0, 5'd0, 64'h0);
        for (int k = 1; k <= 4; k++) begin
            set_pipe(1'b1, 5'(10 + k), 64'h110 + 64'(k));
            tick();
            check("stv_rd_k",    rf_rd, 5'(10 + k));
            check("stv_stall_k", pipe_stall, (k == 4) ? 1 : 0);
        end
        set_pipe(1'b1, 5'd15, 64'h115);
        tick();
        check("stv_frc_rd",    rf_rd, 3);
        check("stv_frc_wdata", rf_wdata, 64'h333);
        check("stv_frc_stall", pipe_stall, 0);
        tick();
        check("stv_held_we",    rf_we, 1);
        check("stv_held_rd",    rf_rd, 15);
        check("stv_held_wdata", rf_wdata, 64'h115);
        set_pipe(1'b0, 5'd0, 64'h0);
        tick();
        check("stv_idle_we", rf_we, 0);

        // x0 suppression
        set_pipe(1'b1, 5'd0, 64'h1234);
        tick();
        check("x0_pipe_we", rf_we, 0);
        set_pipe(1'b1, 5'd8, 64'h108);
        set_ext(1'b1, 5'd0, 64'h55);
        tick();
        check("x0_push_we",   rf_we, 1);
        check("x0_push_mask", ext_pending_mask, 0);
        set_pipe(1'b0, 5'd0, 64'h0);
        set_ext(1'b0, 5'd0, 64'h0);
        tick();
        check("x0_pop_we", rf_we, 0);
        // FIFO must now be empty: an extension result bypasses.
        set_ext(1'b1, 5'd4, 64'h444);
        tick();
        check("x0_after_we",   rf_we, 1);
        check("x0_after_rd",   rf_rd, 4);
        check("x0_after_mask", ext_pending_mask, 0);
        set_ext(1'b0, 5'd0, 64'h0);
        tick();

        // Simultaneous push and pop with count 1
        set_pipe(1'b1, 5'd12, 64'h112);
        set_ext(1'b1, 5'd20, 64'hA0);
        tick();
        check("pp_mask0", ext_pending_mask, 32'h1 << 20);
        set_pipe(1'b0, 5'd0, 64'h0);
        set_ext(1'b1, 5'd21, 64'hA1);
        tick();
        check("pp_rd1",    rf_rd, 20);
        check("pp_wdata1", rf_wdata, 64'hA0);
        check("pp_mask1",  ext_pending_mask, 32'h1 << 21);
        check("pp_ready1", ext_ready, 1);
        set_ext(1'b1, 5'd22, 64'hA2);
        tick();
        check("pp_rd2",   rf_rd, 21);
        check("pp_mask2", ext_pending_mask, 32'h1 << 22);
        set_ext(1'b0, 5'd0, 64'h0);
        tick();
        check("pp_rd3",    rf_rd, 22);
        check("pp_wdata3", rf_wdata, 64'hA2);
        check("pp_mask3",  ext_pending_mask, 0);
        tick();
        check("pp_idle_we", rf_we, 0);

        // Asynchronous reset mid-stream with two buffered entries
        set_pipe(1'b1, 5'd1, 64'h201);
        set_ext(1'b1, 5'd6, 64'h606);
        tick();
        set_pipe(1'b1, 5'd2, 64'h202);
        set_ext(1'b1, 5'd7, 64'h707);
        tick();
        check("mid_mask",  ext_pending_mask, 32'hC0);
        check("mid_ready", ext_ready, 0);
        check("mid_we",    rf_we, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_we",    rf_we, 0);
        check("arst_rd",    rf_rd, 0);
        check("arst_wdata", rf_wdata, 0);
        check("arst_stall", pipe_stall, 0);
        check("arst_ready", ext_ready, 1);
        check("arst_mask",  ext_pending_mask, 0);
        set_pipe(1'b0, 5'd0, 64'h0);
        set_ext(1'b0, 5'd0, 64'h0);
        tick();
        rst = 1'b0;
        tick();
        check("post_we",    rf_we, 0);
        check("post_ready", ext_ready, 1);
        check("post_mask",  ext_pending_mask, 0);
        check("post_stall", pipe_stall, 0);
        tick();
        check("post_we2", rf_we, 0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
